banked_storage_controller: RTL and testbench

BANKED_STORAGE_CONTROLLER -- requirements
Module: banked_storage_controller

---
 rtl/banked_storage_controller_if.sv | 54 +++++
 rtl/banked_storage_controller.sv | 177 +++++++++++++++++
 tb/tb_banked_storage_controller.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/banked_storage_controller_if.sv
// Bus bundle for banked_storage_controller: request/response, local SRAM port and external bus.
// slave is the controller's view; master is the environment's view.
interface banked_storage_controller_if #(
    parameter int unsigned MEM_W      = 32,
    parameter int unsigned SRAM_WORDS = 2048,
    parameter int unsigned EXT_AW     = 22
);
    localparam int unsigned Bytes  = MEM_W / 8;
    localparam int unsigned SramAw = $clog2(SRAM_WORDS);

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [31:0]       req_addr;
    logic [MEM_W-1:0]  req_wdata;
    logic [Bytes-1:0]  req_be;
    logic              rsp_valid;
    logic [MEM_W-1:0]  rsp_rdata;
    logic              rsp_err;

    logic              sram_cen;
    logic              sram_wen;
    logic [SramAw-1:0] sram_addr;
    logic [MEM_W-1:0]  sram_wdata;
    logic [MEM_W-1:0]  sram_rdata;

    logic              ext_cyc;
    logic              ext_stb;
    logic              ext_we;
    logic [EXT_AW-1:0] ext_addr;
    logic [MEM_W-1:0]  ext_wdata;
    logic [Bytes-1:0]  ext_sel;
    logic              ext_stall;
    logic              ext_ack;
    logic [MEM_W-1:0]  ext_rdata;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output sram_cen, sram_wen, sram_addr, sram_wdata,
        input  sram_rdata,
        output ext_cyc, ext_stb, ext_we, ext_addr, ext_wdata, ext_sel,
        input  ext_stall, ext_ack, ext_rdata
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  sram_cen, sram_wen, sram_addr, sram_wdata,
        output sram_rdata,
        input  ext_cyc, ext_stb, ext_we, ext_addr, ext_wdata, ext_sel,
        output ext_stall, ext_ack, ext_rdata
    );
endinterface

// File: rtl/banked_storage_controller.sv
// Single-outstanding request controller splitting a byte address space between a local SRAM
// (with read-modify-write for partial writes) and a pipelined external bus with timeout.
module banked_storage_controller #(
    parameter int unsigned MEM_W       = 32,
    parameter int unsigned SRAM_WORDS  = 2048,
    parameter int unsigned EXT_AW      = 22,
    parameter int unsigned EXT_TIMEOUT = 1023
) (
    input  logic                      clk,
    input  logic                      rst,
    banked_storage_controller_if.slave bus
);
    localparam int unsigned Bytes     = MEM_W / 8;
    localparam int unsigned OffW      = $clog2(Bytes);
    localparam int unsigned SramAw    = $clog2(SRAM_WORDS);
    localparam int unsigned CntW      = $clog2(EXT_TIMEOUT + 1);
    localparam logic [63:0] SramBytes = 64'(SRAM_WORDS) * 64'(Bytes);
    localparam logic [63:0] ExtEnd    = SramBytes + (64'd1 << EXT_AW) * 64'(Bytes);
    localparam logic [CntW-1:0] CntLast = CntW'(EXT_TIMEOUT - 1);

    typedef enum logic [2:0] {
        StIdle, StSramRd, StSramMerge, StExtReq, StExtWait, StResp
    } state_e;

    state_e             state_q;
    logic [CntW-1:0]    cnt_q;
    logic               we_q;
    logic [Bytes-1:0]   be_q;
    logic [MEM_W-1:0]   wdata_q;
    logic               noacc_q, dec_err_q, sram_pass_q;
    logic               sram_cen_q, sram_wen_q;
    logic [SramAw-1:0]  sram_addr_q;
    logic               ext_cyc_q, ext_stb_q, ext_we_q;
    logic [EXT_AW-1:0]  ext_addr_q;
    logic [Bytes-1:0]   ext_sel_q;
    logic               rsp_valid_q, rsp_err_q;
    logic [MEM_W-1:0]   rdata_q;

    logic               is_sram, is_ext, ext_done, ext_tmo;
    logic [MEM_W-1:0]   merged;

    always_comb begin
        is_sram  = {32'd0, bus.req_addr} < SramBytes;
        is_ext   = !is_sram && ({32'd0, bus.req_addr} < ExtEnd);
        // An ack is only meaningful once the strobe has been taken (stall low).
        ext_done = bus.ext_ack && ((state_q == StExtWait) || !bus.ext_stall);
        ext_tmo  = (cnt_q == CntLast);
        merged   = '0;
        for (int b = 0; b < Bytes; b++) begin
            merged[8*b +: 8] = be_q[b] ? wdata_q[8*b +: 8] : bus.sram_rdata[8*b +: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            we_q        <= 1'b0;
            be_q        <= '0;
            wdata_q     <= '0;
            noacc_q     <= 1'b0;
            dec_err_q   <= 1'b0;
            sram_pass_q <= 1'b0;
            sram_cen_q  <= 1'b0;
            sram_wen_q  <= 1'b0;
            sram_addr_q <= '0;
            ext_cyc_q   <= 1'b0;
            ext_stb_q   <= 1'b0;
            ext_we_q    <= 1'b0;
            ext_addr_q  <= '0;
            ext_sel_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rdata_q     <= '0;
        end else begin
            rsp_valid_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.req_valid) begin
                        we_q      <= bus.req_we;
                        be_q      <= bus.req_be;
                        wdata_q   <= bus.req_wdata;
                        noacc_q   <= 1'b0;
                        dec_err_q <= 1'b0;
                        // Requests without an access still spend one cycle in StSramRd
                        // (chip enable held low) so every response lands >= 2 cycles out.
                        if (!is_sram && !is_ext) begin
                            noacc_q   <= 1'b1;
                            dec_err_q <= 1'b1;
                            state_q   <= StSramRd;
                        end else if (bus.req_we && (bus.req_be == '0)) begin
                            noacc_q <= 1'b1;
                            state_q <= StSramRd;
                        end else if (is_sram) begin
                            sram_cen_q  <= 1'b1;
                            sram_wen_q  <= bus.req_we && (&bus.req_be);
                            sram_addr_q <= SramAw'(bus.req_addr >> OffW);
                            state_q     <= StSramRd;
                        end else begin
                            ext_cyc_q  <= 1'b1;
                            ext_stb_q  <= 1'b1;
                            ext_we_q   <= bus.req_we;
                            ext_addr_q <= EXT_AW'((bus.req_addr - 32'(SramBytes)) >> OffW);
                            ext_sel_q  <= bus.req_be;
                            cnt_q      <= CntW'(1);
                            state_q    <= StExtReq;
                        end
                    end
                end
                StSramRd: begin
                    if (!noacc_q && we_q && !(&be_q)) begin
                        sram_wen_q <= 1'b1;
                        state_q    <= StSramMerge;
                    end else begin
                        sram_cen_q  <= 1'b0;
                        sram_wen_q  <= 1'b0;
                        sram_pass_q <= !noacc_q && !we_q;
                        rsp_err_q   <= dec_err_q;
                        rsp_valid_q <= 1'b1;
                        state_q     <= StResp;
                    end
                end
                StSramMerge: begin
                    sram_cen_q  <= 1'b0;
                    sram_wen_q  <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    state_q     <= StResp;
                end
                StExtReq, StExtWait: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (ext_done) begin
                        ext_cyc_q   <= 1'b0;
                        ext_stb_q   <= 1'b0;
                        rdata_q     <= we_q ? '0 : bus.ext_rdata;
                        rsp_valid_q <= 1'b1;
                        state_q     <= StResp;
                    end else if (ext_tmo) begin
                        ext_cyc_q   <= 1'b0;
                        ext_stb_q   <= 1'b0;
                        rdata_q     <= '0;
                        rsp_err_q   <= 1'b1;
                        rsp_valid_q <= 1'b1;
                        state_q     <= StResp;
                    end else if ((state_q == StExtReq) && !bus.ext_stall) begin
                        ext_stb_q <= 1'b0;
                        state_q   <= StExtWait;
                    end
                end
                StResp: begin
                    rsp_err_q   <= 1'b0;
                    rdata_q     <= '0;
                    sram_pass_q <= 1'b0;
                    state_q     <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Outputs are forced low while rst is high, even before the synchronous reset takes effect.
    always_comb begin
        bus.req_ready  = (state_q == StIdle) && !rst;
        bus.rsp_valid  = rsp_valid_q && !rst;
        bus.rsp_err    = rsp_err_q && !rst;
        bus.rsp_rdata  = rst ? '0 : (sram_pass_q ? bus.sram_rdata : rdata_q);
        bus.sram_cen   = sram_cen_q && !rst;
        bus.sram_wen   = sram_wen_q && !rst;
        bus.sram_addr  = rst ? '0 : sram_addr_q;
        bus.sram_wdata = rst ? '0 : ((state_q == StSramMerge) ? merged : wdata_q);
        bus.ext_cyc    = ext_cyc_q && !rst;
        bus.ext_stb    = ext_stb_q && !rst;
        bus.ext_we     = ext_we_q && !rst;
        bus.ext_addr   = rst ? '0 : ext_addr_q;
        bus.ext_wdata  = rst ? '0 : wdata_q;
        bus.ext_sel    = rst ? '0 : ext_sel_q;
    end
endmodule

// File: tb/tb_banked_storage_controller.sv
// Self-checking bench for banked_storage_controller: SRAM and external-bus models, a response
// scoreboard with latency tracking, a vector table and hand-written reset sequences.
module tb_banked_storage_controller;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    banked_storage_controller_if #(.MEM_W(32), .SRAM_WORDS(2048), .EXT_AW(22)) bus_if ();

    banked_storage_controller #(
        .MEM_W(32), .SRAM_WORDS(2048), .EXT_AW(22), .EXT_TIMEOUT(15)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        int          stall;
        int          ackd;
        logic        acken;
        logic [31:0] xdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          lat;
        int          sram_n;
        logic        ext_used;
        logic [21:0] exp_xaddr;
    } vec_t;

    int checks = 0;
    int errors = 0;
    int cyc_n = 0;
    exp_t sb_q[$];
    vec_t vecs[$];

    int sram_cnt, ext_cnt;
    logic [21:0] xaddr_seen;
    int stall_left, ack_delay, wait_left;
    logic ack_en;
    logic [31:0] xdata;

    always @(posedge clk) cyc_n <= cyc_n + 1;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h required %0h", name, act, exp);
        end
    endfunction

    // Synchronous SRAM: read data appears the cycle after the read.
    logic [31:0] mem [2048];
    always @(posedge clk) begin
        if (bus_if.sram_cen) begin
            if (bus_if.sram_wen) mem[bus_if.sram_addr] <= bus_if.sram_wdata;
            else bus_if.sram_rdata <= mem[bus_if.sram_addr];
        end
    end

    // External responder: stalls the strobe stall_left cycles, then acks ack_delay cycles later.
    initial begin : responder
        bus_if.ext_stall = 1'b0;
        bus_if.ext_ack   = 1'b0;
        bus_if.ext_rdata = '0;
        forever begin
            @(negedge clk);
            bus_if.ext_rdata = xdata;
            bus_if.ext_ack   = 1'b0;
            bus_if.ext_stall = 1'b0;
            if (bus_if.ext_cyc && bus_if.ext_stb) begin
                xaddr_seen = bus_if.ext_addr;
                if (stall_left > 0) begin
                    bus_if.ext_stall = 1'b1;
                    stall_left--;
                end else begin
                    wait_left      = ack_delay;
                    bus_if.ext_ack = ack_en && (ack_delay == 0);
                end
            end else if (bus_if.ext_cyc) begin
                if (wait_left > 1) wait_left--;
                else bus_if.ext_ack = ack_en;
            end
        end
    end

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (bus_if.sram_cen) sram_cnt++;
            if (bus_if.ext_cyc) ext_cnt++;
            if (bus_if.rsp_valid) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL rsp_expected: got rsp_valid=1 at cycle %0d, required 0", cyc_n);
                end else begin
                    e = sb_q.pop_front();
                    chk("rsp_rdata", bus_if.rsp_rdata, e.rdata);
                    chk("rsp_err", bus_if.rsp_err, e.err);
                    chk("rsp_latency", cyc_n, e.due);
                end
            end
        end
    end

    task automatic send(input vec_t v);
        int n;
        bus_if.req_valid = 1'b1;
        bus_if.req_we    = v.we;
        bus_if.req_addr  = v.addr;
        bus_if.req_wdata = v.wdata;
        bus_if.req_be    = v.be;
        n = 0;
        while (!bus_if.req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL req_accept: got req_ready=0 for 50 cycles, required 1");
        end else begin
            sb_q.push_back('{v.exp_rdata, v.exp_err, cyc_n + v.lat});
        end
        @(negedge clk);
        bus_if.req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (sb_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_arrived_pending", sb_q.size(), 0);
        sb_q.delete();
        @(negedge clk);
    endtask

    task automatic chk_rst_outputs(input string tag);
        chk({tag, "_ctrl"}, {bus_if.rsp_valid, bus_if.rsp_err, bus_if.sram_cen, bus_if.sram_wen,
                             bus_if.ext_cyc, bus_if.ext_stb, bus_if.ext_we}, 0);
        chk({tag, "_data"}, |{bus_if.sram_addr, bus_if.sram_wdata, bus_if.ext_addr,
                              bus_if.ext_wdata, bus_if.ext_sel, bus_if.rsp_rdata}, 0);
        chk({tag, "_ready"}, bus_if.req_ready, 0);
    endtask

    initial begin : main
        vec_t v;
        rst = 1'b1;
        bus_if.req_valid = 1'b0;
        bus_if.req_we    = 1'b0;
        bus_if.req_addr  = '0;
        bus_if.req_wdata = '0;
        bus_if.req_be    = '0;
        stall_left = 0;
        ack_delay  = 0;
        wait_left  = 0;
        ack_en     = 1'b0;
        xdata      = '0;
        sram_cnt   = 0;
        ext_cnt    = 0;

        // we addr wdata be stall ackd acken xdata | rdata err lat sram_n ext_used xaddr
        vecs.push_back('{1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 0, 1'b0, 32'h0,
                         32'h0, 1'b0, 2, 1, 1'b0, 22'h0});
        vecs.push_back('{1'b0, 32'h10, 32'h0, 4'hF, 0, 0, 1'b0, 32'h0,
                         32'hDEADBEEF, 1'b0, 2, 1, 1'b0, 22'h0});
        vecs.push_back('{1'b1, 32'h20, 32'h11223344, 4'hF, 0, 0, 1'b0, 32'h0,
                         32'h0, 1'b0, 2, 1, 1'b0, 22'h0});
        vecs.push_back('{1'b1, 32'h20, 32'hAABBCCDD, 4'h5, 0, 0, 1'b0, 32'h0,
                         32'h0, 1'b0, 3, 2, 1'b0, 22'h0});
        vecs.push_back('{1'b0, 32'h20, 32'h0, 4'hF, 0, 0, 1'b0, 32'h0,
                         32'h11BB33DD, 1'b0, 2, 1, 1'b0, 22'h0});
        vecs.push_back('{1'b1, 32'h1FFC, 32'h01020304, 4'hF, 0, 0, 1'b0, 32'h0,
                         32'h0, 1'b0, 2, 1, 1'b0, 22'h0});
        vecs.push_back('{1'b0, 32'h1FFF, 32'h0, 4'hF, 0, 0, 1'b0, 32'h0,
                         32'h01020304, 1'b0, 2, 1, 1'b0, 22'h0});
        vecs.push_back('{1'b0, 32'h2000, 32'h0, 4'hF, 3, 5, 1'b1, 32'hCAFEF00D,
                         32'hCAFEF00D, 1'b0, 10, 0, 1'b1, 22'h0});
        vecs.push_back('{1'b1, 32'h2040, 32'h12345678, 4'hF, 0, 1, 1'b1, 32'hFFFFFFFF,
                         32'h0, 1'b0, 3, 0, 1'b1, 22'h10});
        vecs.push_back('{1'b0, 32'h2008, 32'h0, 4'hF, 0, 0, 1'b1, 32'h5A5A0001,
                         32'h5A5A0001, 1'b0, 2, 0, 1'b1, 22'h2});
        vecs.push_back('{1'b0, 32'h01001FFC, 32'h0, 4'hF, 0, 2, 1'b1, 32'h0BADCAFE,
                         32'h0BADCAFE, 1'b0, 4, 0, 1'b1, 22'h3FFFFF});
        vecs.push_back('{1'b0, 32'h3000, 32'h0, 4'hF, 0, 0, 1'b0, 32'h77777777,
                         32'h0, 1'b1, 15, 0, 1'b1, 22'h400});
        vecs.push_back('{1'b0, 32'hFFFFFFF0, 32'h0, 4'hF, 0, 0, 1'b1, 32'h0,
                         32'h0, 1'b1, 2, 0, 1'b0, 22'h0});
        vecs.push_back('{1'b0, 32'h01002000, 32'h0, 4'hF, 0, 0, 1'b1, 32'h0,
                         32'h0, 1'b1, 2, 0, 1'b0, 22'h0});
        vecs.push_back('{1'b1, 32'h10, 32'h0BADBEEF, 4'h0, 0, 0, 1'b0, 32'h0,
                         32'h0, 1'b0, 2, 0, 1'b0, 22'h0});
        vecs.push_back('{1'b0, 32'h10, 32'h0, 4'hF, 0, 0, 1'b0, 32'h0,
                         32'hDEADBEEF, 1'b0, 2, 1, 1'b0, 22'h0});

        repeat (3) @(negedge clk);
        chk_rst_outputs("por");
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_por", bus_if.req_ready, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            v          = vecs[i];
            stall_left = v.stall;
            ack_delay  = v.ackd;
            ack_en     = v.acken;
            xdata      = v.xdata;
            sram_cnt   = 0;
            ext_cnt    = 0;
            xaddr_seen = '1;
            send(v);
            wait_done();
            chk($sformatf("v%0d_sram_cycles", i), sram_cnt, v.sram_n);
            chk($sformatf("v%0d_ext_used", i), ext_cnt != 0, v.ext_used);
            if (v.ext_used) chk($sformatf("v%0d_ext_addr", i), xaddr_seen, v.exp_xaddr);
            chk($sformatf("v%0d_ext_cyc_idle", i), bus_if.ext_cyc, 0);
        end

        // Reset while waiting for an ack that never comes.
        stall_left = 0;
        ack_delay  = 0;
        ack_en     = 1'b0;
        send('{1'b0, 32'h2100, 32'h0, 4'hF, 0, 0, 1'b0, 32'h0,
               32'h0, 1'b1, 15, 0, 1'b1, 22'h40});
        @(negedge clk);
        chk("pre_rst_in_wait", {bus_if.ext_cyc, bus_if.ext_stb}, 2'b10);
        chk("pre_rst_ext_addr", bus_if.ext_addr, 22'h40);
        rst = 1'b1;
        #1;
        chk_rst_outputs("mid_rst");
        sb_q.delete();
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("ready_after_mid_rst", bus_if.req_ready, 1);
        repeat (20) @(negedge clk);
        chk("ext_cyc_after_mid_rst", bus_if.ext_cyc, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no finish by 200000 time units, required earlier finish");
        $fatal(1);
    end
endmodule
